intern_ram_dp: RTL and testbench

INTERN_RAM_DP -- requirements
Module: intern_ram_dp

---
 rtl/intern_ram_dp.sv | 186 ++++++++++++++++++
 tb/tb_intern_ram_dp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/intern_ram_dp.sv
// intern_ram_dp: true dual-port byte-writable RAM with a post-reset zero sweep.
//   clk, rst                 : single clock, asynchronous active-high reset
//   req_x, we_x, be_x        : port request, write select, byte-lane enables
//   addr_x, wdata_x          : word address and write data
//   ready                    : high once requests are accepted (after CLEAR)
//   rvalid_x, rdata_x        : read data pulse, RD_LAT cycles after acceptance;
//                              rdata_x holds its last value between pulses
module intern_ram_dp #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   wdata_a,
    input  logic                req_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   wdata_b,
    output logic                ready,
    output logic                rvalid_a,
    output logic [DATA_W-1:0]   rdata_a,
    output logic                rvalid_b,
    output logic [DATA_W-1:0]   rdata_b
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;

    // stage-1 read pipeline (only used when RD_LAT == 2)
    logic                p1_v_a_q, p1_v_a_d, p1_v_b_q, p1_v_b_d;
    logic [DATA_W-1:0]   p1_d_a_q, p1_d_a_d, p1_d_b_q, p1_d_b_d;

    logic                rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

    logic                wr_a, rd_a, wr_b, rd_b;
    logic [DATA_W-1:0]   old_a, old_b, rword_a, rword_b;
    logic                src_v_a, src_v_b;
    logic [DATA_W-1:0]   src_d_a, src_d_b;

    // Apply enabled byte lanes of wd onto old.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] wd,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < int'(NB); i++) begin
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    assign wr_a = req_a & ready_q & we_a;
    assign rd_a = req_a & ready_q & ~we_a;
    assign wr_b = req_b & ready_q & we_b;
    assign rd_b = req_b & ready_q & ~we_b;

    // Read word selection; write-first folds in the other port's same-edge write.
    always_comb begin
        old_a   = mem[addr_a];
        old_b   = mem[addr_b];
        rword_a = old_a;
        rword_b = old_b;
        if (RD_MODE != 0) begin
            if (wr_b && (addr_b == addr_a)) rword_a = merge_bytes(old_a, wdata_b, be_b);
            if (wr_a && (addr_a == addr_b)) rword_b = merge_bytes(old_b, wdata_a, be_a);
        end
    end

    // Next-state: CLEAR sweep then RUN forever; read pipeline.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        p1_v_a_d   = rd_a;
        p1_v_b_d   = rd_b;
        p1_d_a_d   = p1_d_a_q;
        p1_d_b_d   = p1_d_b_q;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;

        case (state_q)
            S_CLEAR: begin
                ready_d = 1'b0;
                if (cnt_q == '1) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_RUN: ready_d = 1'b1;
            default: begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        endcase

        if (rd_a) p1_d_a_d = rword_a;
        if (rd_b) p1_d_b_d = rword_b;

        src_v_a = (RD_LAT == 2) ? p1_v_a_q : rd_a;
        src_d_a = (RD_LAT == 2) ? p1_d_a_q : rword_a;
        src_v_b = (RD_LAT == 2) ? p1_v_b_q : rd_b;
        src_d_b = (RD_LAT == 2) ? p1_d_b_q : rword_b;

        rvalid_a_d = src_v_a;
        rvalid_b_d = src_v_b;
        if (src_v_a) rdata_a_d = src_d_a;
        if (src_v_b) rdata_b_d = src_d_b;
    end

    // Control and read-pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            p1_v_a_q   <= 1'b0;
            p1_v_b_q   <= 1'b0;
            p1_d_a_q   <= '0;
            p1_d_b_q   <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            p1_v_a_q   <= p1_v_a_d;
            p1_v_b_q   <= p1_v_b_d;
            p1_d_a_q   <= p1_d_a_d;
            p1_d_b_q   <= p1_d_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    // Storage array; port B lanes are applied last so B wins shared lanes.
    // The sweep may also touch address 0 while rst is held, which is harmless
    // because the sweep restarts there on release.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_a) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (be_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
                end
            end
            if (wr_b) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (be_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
                end
            end
        end
    end

    assign ready    = ready_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_intern_ram_dp.sv
// Bench for intern_ram_dp: two instances (read-first RD_LAT=2, write-first
// RD_LAT=1) share stimulus and are compared against a word-array model.
module tb_intern_ram_dp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [3:0]    be_a = '0, be_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;

    logic          rdy [2];
    logic          rv  [2][2];
    logic [DW-1:0] rd  [2][2];

    intern_ram_dp #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RD_MODE(0), .INIT_CLEAR(1)) u_rf (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ready(rdy[0]), .rvalid_a(rv[0][0]), .rdata_a(rd[0][0]),
        .rvalid_b(rv[0][1]), .rdata_b(rd[0][1]));

    intern_ram_dp #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RD_MODE(1), .INIT_CLEAR(1)) u_wf (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ready(rdy[1]), .rvalid_a(rv[1][0]), .rdata_a(rd[1][0]),
        .rvalid_b(rv[1][1]), .rdata_b(rd[1][1]));

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic [31:0] m_mem [DEPTH];
    exp_t        q [4][$];       // index = inst*2 + port
    logic [31:0] last [4];
    int          ecount    = 0;
    int          since_rel = 0;
    bit          in_rst    = 1'b1;
    int          n_chk     = 0;
    int          n_pass    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecount);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    function automatic bit model_ready();
        return !in_rst && (since_rel >= int'(DEPTH));
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ready i%0d", i), 64'(rdy[i]), 64'(model_ready()));
            for (int p = 0; p < 2; p++) begin
                int k;
                bit ev;
                k  = i * 2 + p;
                ev = (q[k].size() > 0) && (q[k][0].due == ecount);
                check($sformatf("rvalid i%0d p%0d", i, p), 64'(rv[i][p]), 64'(ev));
                if (ev) begin
                    last[k] = q[k][0].d;
                    void'(q[k].pop_front());
                end
                check($sformatf("rdata i%0d p%0d", i, p), 64'(rd[i][p]), 64'(last[k]));
            end
        end
    endtask

    task automatic step(input bit ra, input bit wa, input logic [3:0] bea,
                        input logic [3:0] aa, input logic [31:0] da,
                        input bit rb, input bit wb, input logic [3:0] beb,
                        input logic [3:0] ab, input logic [31:0] db);
        bit acc_a, acc_b;
        logic [31:0] old;
        check_outputs();
        req_a = ra; we_a = wa; be_a = bea; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; be_b = beb; addr_b = ab; wdata_b = db;
        acc_a = ra && model_ready();
        acc_b = rb && model_ready();
        if (acc_a && !wa) begin
            old = m_mem[aa];
            q[0].push_back('{ecount + 2, old});
            q[2].push_back('{ecount + 1, (acc_b && wb && ab == aa) ? merge(old, db, beb) : old});
        end
        if (acc_b && !wb) begin
            old = m_mem[ab];
            q[1].push_back('{ecount + 2, old});
            q[3].push_back('{ecount + 1, (acc_a && wa && aa == ab) ? merge(old, da, bea) : old});
        end
        if (acc_a && wa) m_mem[aa] = merge(m_mem[aa], da, bea);
        if (acc_b && wb) m_mem[ab] = merge(m_mem[ab], db, beb);
        @(posedge clk);
        ecount++;
        since_rel++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic rnd_step();
        step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
             $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
             $urandom);
    endtask

    // Assert rst asynchronously at a negedge, hold across one edge, release.
    task automatic do_reset();
        check_outputs();
        rst = 1'b1;
        in_rst = 1'b1;
        req_a = 1'b1; we_a = 1'b1; be_a = 4'hF; wdata_a = 32'hFFFF_FFFF;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst ready i%0d", i), 64'(rdy[i]), 64'(0));
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rst rvalid i%0d p%0d", i, p), 64'(rv[i][p]), 64'(0));
                check($sformatf("rst rdata i%0d p%0d", i, p), 64'(rd[i][p]), 64'(0));
            end
        end
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = '0;
        end
        @(posedge clk);
        ecount++;
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        in_rst = 1'b0;
        since_rel = 0;
        for (int a = 0; a < int'(DEPTH); a++) m_mem[a] = '0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) last[k] = '0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // Requests during the sweep must be ignored; ready timing checked each cycle.
        for (int i = 0; i < int'(DEPTH); i++) rnd_step();
        for (int i = 0; i < int'(DEPTH); i++)
            step(1, 0, 4'hF, 4'(i), 32'h0, 1, 0, 4'hF, 4'(15 - i), 32'h0);
        idle(3);

        step(1, 1, 4'hF, 4'd3, 32'hDEAD_BEEF, 0, 0, 4'h0, 4'h0, 32'h0);
        step(1, 0, 4'h0, 4'd3, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        idle(3);

        step(1, 1, 4'hF, 4'd5, 32'h1122_3344, 0, 0, 4'h0, 4'h0, 32'h0);
        step(1, 1, 4'b0101, 4'd5, 32'hAABB_CCDD, 0, 0, 4'h0, 4'h0, 32'h0);
        step(0, 0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 4'd5, 32'h0);
        step(0, 0, 4'h0, 4'h0, 32'h0, 1, 1, 4'h0, 4'd5, 32'hFFFF_FFFF);
        step(1, 0, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        idle(3);

        step(1, 1, 4'b0011, 4'd7, 32'h0000_00FF, 1, 1, 4'b0010, 4'd7, 32'h0000_AA00);
        step(1, 0, 4'h0, 4'd7, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        idle(3);

        step(1, 1, 4'hF, 4'd9, 32'h1234_5678, 0, 0, 4'h0, 4'h0, 32'h0);
        step(1, 1, 4'hF, 4'd9, 32'hCAFE_F00D, 1, 0, 4'h0, 4'd9, 32'h0);
        step(1, 0, 4'h0, 4'd9, 32'h0, 1, 1, 4'b1001, 4'd9, 32'h5500_0066);
        idle(3);

        for (int i = 0; i < 300; i++) rnd_step();
        idle(3);

        // Reset while reads are in flight: no late rvalid, sweep restarts.
        step(1, 0, 4'h0, 4'd3, 32'h0, 1, 0, 4'h0, 4'd9, 32'h0);
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) rnd_step();
        step(1, 0, 4'h0, 4'd3, 32'h0, 1, 0, 4'h0, 4'd9, 32'h0);
        for (int i = 0; i < 40; i++) rnd_step();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
